// File: rtl/uart_tx_fifo_if.sv
// Host/transmitter signal bundle for uart_tx_fifo.
// UART_TXFIFO_OVERFLOW_EN adds the overflow/ovf_clr pair.
interface uart_tx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;

`ifdef UART_TXFIFO_OVERFLOW_EN
  logic              overflow;
  logic              ovf_clr;

  modport master (
    output wr_en, wr_data, tx_busy, ovf_clr,
    input  full, empty, level, tx_start, tx_data, overflow
  );

  modport slave (
    input  wr_en, wr_data, tx_busy, ovf_clr,
    output full, empty, level, tx_start, tx_data, overflow
  );
`else
  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, level, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, level, tx_start, tx_data
  );
`endif

endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter through a start/busy handshake.
// Optional sticky overflow flag under UART_TXFIFO_OVERFLOW_EN.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  generate
    if ((DEPTH < 2) || (DEPTH != (32'd1 << ADDR_W))) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_meta_q, busy_s_q;
  logic [7:0]        mem_q [DEPTH];

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full  = (level_q == LEVEL_MAX);
  assign empty = (level_q == '0);
  assign push  = bus.wr_en && !full;

  // tx_busy comes from the baud domain; only busy_s is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      busy_meta_q <= bus.tx_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // tx_start is registered from the next state so it tracks LAUNCH/WAIT_ACK exactly.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !busy_s_q) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (busy_s_q) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!busy_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    tx_start_d = (state_d == LAUNCH) || (state_d == WAIT_ACK);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    tx_data_d = tx_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

`ifdef UART_TXFIFO_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // A dropped write in the same cycle as ovf_clr must leave the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (bus.wr_en && full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table plus scoreboarded transmitter model.
module tb_uart_tx_fifo;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DEPTH     = 16;
  localparam int          FRAME_LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_busy;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       tx_start;
    logic [7:0] tx_data;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         model_en = 1'b0;
  bit         start_prev = 1'b0;
  int         frame_cnt = 0;
  int         n_sent = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: accepts a new launch, raises busy for a frame, scores tx_data.
  task automatic tx_model();
    if (model_en) begin
      if (bus.tx_busy) begin
        if (frame_cnt == 0) bus.tx_busy = 1'b0;
        else frame_cnt--;
      end else if (bus.tx_start && !start_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_tx: got 0x%0h, want no launch at %0t", bus.tx_data, $time);
        end else begin
          check("tx_order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
        n_sent++;
        bus.tx_busy = 1'b1;
        frame_cnt   = FRAME_LEN;
      end
    end
    start_prev = bus.tx_start;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tx_model();
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while (i < budget && (exp_q.size() != 0 || bus.tx_busy)) begin
      tick();
      i++;
    end
    check("drain_done", 32'(exp_q.size()), 0);
    repeat (6) tick();
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.wr_en   = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      bus.tx_busy = vecs[i].tx_busy;
      tick();
      bus.wr_en = 1'b0;
      check($sformatf("v%0d_level", i),    32'(bus.level),    32'(vecs[i].level));
      check($sformatf("v%0d_full", i),     32'(bus.full),     32'(vecs[i].full));
      check($sformatf("v%0d_empty", i),    32'(bus.empty),    32'(vecs[i].empty));
      check($sformatf("v%0d_tx_start", i), 32'(bus.tx_start), 32'(vecs[i].tx_start));
      check($sformatf("v%0d_tx_data", i),  32'(bus.tx_data),  32'(vecs[i].tx_data));
    end
  endtask

  initial begin
    //            wr    data   busy  lvl   full  empty start data
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'hA5};

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_busy = 1'b0;
`ifdef UART_TXFIFO_OVERFLOW_EN
    bus.ovf_clr = 1'b0;
`endif

    // Reset, then idle
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_empty",    32'(bus.empty),    1);
    check("rst_full",     32'(bus.full),     0);
    check("rst_level",    32'(bus.level),    0);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data",  32'(bus.tx_data),  0);
`ifdef UART_TXFIFO_OVERFLOW_EN
    check("rst_overflow", 32'(bus.overflow), 0);
`endif

    // Single byte: launch latency and tx_start hold until busy is seen
    run_vecs(0, 2);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_tx_start", 32'(bus.tx_start), 1);
    end
    run_vecs(3, 8);

    // Fill to full with the transmitter busy, then overflow
    bus.tx_busy = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 16; k++) write_byte(8'(k), 1'b1);
    check("fill_full",     32'(bus.full),     1);
    check("fill_level",    32'(bus.level),    16);
    check("fill_empty",    32'(bus.empty),    0);
    check("fill_tx_start", 32'(bus.tx_start), 0);
    write_byte(8'hFF, 1'b0);
    check("ovf_level", 32'(bus.level), 16);
    check("ovf_full",  32'(bus.full),  1);
`ifdef UART_TXFIFO_OVERFLOW_EN
    check("ovf_set", 32'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    write_byte(8'hFE, 1'b0);
    check("ovf_set_wins", 32'(bus.overflow), 1);
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", 32'(bus.overflow), 0);
`endif
    n_sent      = 0;
    bus.tx_busy = 1'b0;
    model_en    = 1'b1;
    drain(16 * (FRAME_LEN + 12) + 50);
    check("fill_sent",        32'(n_sent),    16);
    check("fill_drain_level", 32'(bus.level), 0);
    check("fill_drain_empty", 32'(bus.empty), 1);

    // Bursts with drains so both pointers wrap
    n_sent = 0;
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 8; j++) write_byte(8'((b * 8 + j) * 37 + 11), 1'b1);
      drain(8 * (FRAME_LEN + 12) + 50);
    end
    check("wrap_sent", 32'(n_sent), 40);

    // Write landing in the pop cycle at level 1
    n_sent = 0;
    write_byte(8'h3C, 1'b1);
    check("l1_pre_level", 32'(bus.level), 1);
    write_byte(8'hC3, 1'b1);
    check("l1_pop_level",    32'(bus.level),    1);
    check("l1_pop_tx_start", 32'(bus.tx_start), 1);
    drain(2 * (FRAME_LEN + 12) + 50);
    check("l1_sent", 32'(n_sent), 2);

    // Reset while waiting for the transmitter acknowledge
    model_en    = 1'b0;
    bus.tx_busy = 1'b0;
    for (int k = 0; k < 6; k++) write_byte(8'(8'h80 + k), 1'b0);
    check("ack_level",    32'(bus.level),    5);
    check("ack_tx_start", 32'(bus.tx_start), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_tx_start", 32'(bus.tx_start), 0);
    check("mid_rst_level",    32'(bus.level),    0);
    check("mid_rst_empty",    32'(bus.empty),    1);
    check("mid_rst_tx_data",  32'(bus.tx_data),  0);
    n_sent   = 0;
    model_en = 1'b1;
    write_byte(8'h5A, 1'b1);
    drain(FRAME_LEN + 60);
    check("post_rst_sent", 32'(n_sent), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
